// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned REG_BUS = 64;

  localparam logic MULDIV_SIGN   = 1'b1;
  localparam logic MULDIV_UNSIGN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operation attributes captured at accept time
  typedef struct packed {
    logic mul;    // 1 = multiply, 0 = divide/remainder
    logic neg_q;  // negate product / quotient
    logic neg_r;  // negate remainder (dividend sign)
  } op_t;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage request/response bundle for the multiply/divide unit.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int unsigned XLEN = REG_BUS
);
  logic            req_valid_i;
  logic            mul_en_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            rs1_sign_i;
  logic            rs2_sign_i;
  logic            flush_i;
  logic            req_ready_o;
  logic            busy_o;
  logic            resp_valid_o;
  logic [XLEN-1:0] data_1_o;
  logic [XLEN-1:0] data_2_o;

  modport master (
    output req_valid_i, mul_en_i, rs1_data_i, rs2_data_i, rs1_sign_i, rs2_sign_i, flush_i,
    input  req_ready_o, busy_o, resp_valid_o, data_1_o, data_2_o
  );

  modport slave (
    input  req_valid_i, mul_en_i, rs1_data_i, rs2_data_i, rs1_sign_i, rs2_sign_i, flush_i,
    output req_ready_o, busy_o, resp_valid_o, data_1_o, data_2_o
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation.
module muldiv_signfix #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] data,
  input  logic         neg,
  output logic [W-1:0] result_c
);

  // Negate when requested, pass through otherwise
  assign result_c = neg ? (~data + W'(1)) : data;

endmodule

// File: rtl/muldiv.sv
// Iterative radix-2 shift-add multiplier / restoring divider.
module muldiv import muldiv_pkg::*; #(
  parameter int unsigned XLEN = REG_BUS
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  op_t                op;
  logic [XLEN-1:0]    acc_hi, acc_lo, op_b;
  logic [XLEN-1:0]    acc_hi_next, acc_lo_next;
  logic [XLEN-1:0]    data_1_q, data_2_q;
  logic               accept, div0, load_out;
  logic               rs1_neg, rs2_neg;
  logic [XLEN-1:0]    rs1_mag_c, rs2_mag_c;
  logic [XLEN:0]      mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]  prod_fix_c;
  logic [XLEN-1:0]    quot_fix_c, rem_fix_c, rem_src;

  assign accept  = (state == IDLE) && bus.req_valid_i && !bus.flush_i;
  assign div0    = !op.mul && (op_b == '0);
  assign rs1_neg = (bus.rs1_sign_i == MULDIV_SIGN) && bus.rs1_data_i[XLEN-1];
  assign rs2_neg = (bus.rs2_sign_i == MULDIV_SIGN) && bus.rs2_data_i[XLEN-1];

  muldiv_signfix #(.W(XLEN)) u_rs1_abs (.data(bus.rs1_data_i), .neg(rs1_neg), .result_c(rs1_mag_c));
  muldiv_signfix #(.W(XLEN)) u_rs2_abs (.data(bus.rs2_data_i), .neg(rs2_neg), .result_c(rs2_mag_c));

  // State and iteration counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state; flush beats both accept and completion
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_out   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = CALC;
          cnt_next   = '0;
        end
      end
      CALC: begin
        if (bus.flush_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (div0 || (cnt == CNT_W'(XLEN-1))) begin
          state_next = DONE;
          cnt_next   = '0;
          load_out   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One multiply or divide step; both share the hi/lo accumulator
  always_comb begin
    mul_sum     = {1'b0, acc_hi} + {1'b0, op_b};
    div_shift   = {acc_hi, acc_lo[XLEN-1]};
    div_diff    = div_shift - {1'b0, op_b};
    acc_hi_next = acc_hi;
    acc_lo_next = acc_lo;
    if (op.mul) begin
      if (acc_lo[0]) {acc_hi_next, acc_lo_next} = {mul_sum, acc_lo[XLEN-1:1]};
      else           {acc_hi_next, acc_lo_next} = {1'b0, acc_hi, acc_lo[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      acc_hi_next = div_diff[XLEN-1:0];
      acc_lo_next = {acc_lo[XLEN-2:0], 1'b1};
    end else begin
      acc_hi_next = div_shift[XLEN-1:0];
      acc_lo_next = {acc_lo[XLEN-2:0], 1'b0};
    end
  end

  // On divide-by-zero the untouched dividend magnitude is re-signed as the remainder
  assign rem_src = div0 ? acc_lo : acc_hi_next;

  muldiv_signfix #(.W(2*XLEN)) u_prod_fix (.data({acc_hi_next, acc_lo_next}), .neg(op.neg_q), .result_c(prod_fix_c));
  muldiv_signfix #(.W(XLEN))   u_quot_fix (.data(acc_lo_next), .neg(op.neg_q), .result_c(quot_fix_c));
  muldiv_signfix #(.W(XLEN))   u_rem_fix  (.data(rem_src),     .neg(op.neg_r), .result_c(rem_fix_c));

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      op_b     <= '0;
      data_1_q <= '0;
      data_2_q <= '0;
    end else begin
      if (accept) begin
        op       <= '{mul: bus.mul_en_i, neg_q: rs1_neg ^ rs2_neg, neg_r: rs1_neg};
        acc_hi   <= '0;
        acc_lo   <= rs1_mag_c;
        op_b     <= rs2_mag_c;
      end else if ((state == CALC) && !div0) begin
        acc_hi   <= acc_hi_next;
        acc_lo   <= acc_lo_next;
      end
      if (load_out) begin
        if (op.mul) begin
          {data_2_q, data_1_q} <= prod_fix_c;
        end else if (div0) begin
          data_1_q <= '1;
          data_2_q <= rem_fix_c;
        end else begin
          data_1_q <= quot_fix_c;
          data_2_q <= rem_fix_c;
        end
      end
    end
  end

  assign bus.req_ready_o  = (state == IDLE) && rst;
  assign bus.busy_o       = (state == CALC) || (state == DONE);
  assign bus.resp_valid_o = (state == DONE) && !bus.flush_i;
  assign bus.data_1_o     = data_1_q;
  assign bus.data_2_o     = data_2_q;

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: random and corner operations against an arithmetic model.
module tb_muldiv;
  import muldiv_pkg::*;

  typedef struct {
    logic [63:0] d1;
    logic [63:0] d2;
    int          lat;
    int          cyc0;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sbq[$];
  logic [63:0] last_d1, last_d2;

  muldiv_if #(.XLEN(64)) bus ();

  muldiv #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width signed arithmetic on sign- or zero-extended operands
  function automatic void model(input logic m, input logic s1, input logic s2,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] d1, output logic [63:0] d2);
    logic signed [129:0] ea, eb, r;
    ea = $signed({{66{s1 & a[63]}}, a});
    eb = $signed({{66{s2 & b[63]}}, b});
    if (m) begin
      r  = ea * eb;
      d1 = r[63:0];
      d2 = r[127:64];
    end else if (b == 64'd0) begin
      d1 = '1;
      d2 = a;
    end else begin
      r  = ea / eb;
      d1 = r[63:0];
      r  = ea % eb;
      d2 = r[63:0];
    end
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.resp_valid_o === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got resp_valid=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("data_1", bus.data_1_o, e.d1);
        chk("data_2", bus.data_2_o, e.d2);
        chk("latency", 64'(cyc - e.cyc0 + 1), 64'(e.lat));
        last_d1 = e.d1;
        last_d2 = e.d2;
      end
    end
  end

  task automatic start(input logic m, input logic s1, input logic s2,
                       input logic [63:0] a, input logic [63:0] b,
                       input bit push, input bit hold);
    logic [63:0] d1, d2;
    for (int i = 0; i < 200 && bus.req_ready_o !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.mul_en_i    = m;
    bus.rs1_sign_i  = s1;
    bus.rs2_sign_i  = s2;
    bus.rs1_data_i  = a;
    bus.rs2_data_i  = b;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    if (push) begin
      model(m, s1, s2, a, b, d1, d2);
      sbq.push_back('{d1: d1, d2: d2, lat: (!m && b == 64'd0) ? 2 : 65, cyc0: cyc});
    end
    if (!hold) bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_resp();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("busy_in_flight", 64'(bus.busy_o), 64'd1);
        chk("ready_in_flight", 64'(bus.req_ready_o), 64'd0);
      end
      if (bus.resp_valid_o === 1'b1) begin
        seen = 1'b1;
        bus.req_valid_i = 1'b0;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no resp_valid in 100 cycles expected one");
      bus.req_valid_i = 1'b0;
    end
  endtask

  task automatic run(input logic m, input logic s1, input logic s2,
                     input logic [63:0] a, input logic [63:0] b, input bit hold);
    start(m, s1, s2, a, b, 1'b1, hold);
    wait_resp();
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = '1;
      3: v = 64'h8000_0000_0000_0000;
      4: v = 64'($urandom_range(0, 100));
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    cyc = 0; checks = 0; errors = 0;
    last_d1 = '0; last_d2 = '0;
    bus.req_valid_i = 1'b0;
    bus.mul_en_i    = 1'b0;
    bus.rs1_data_i  = '0;
    bus.rs2_data_i  = '0;
    bus.rs1_sign_i  = MULDIV_UNSIGN;
    bus.rs2_sign_i  = MULDIV_UNSIGN;
    bus.flush_i     = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_resp", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_data_1", bus.data_1_o, 64'd0);
    chk("rst_data_2", bus.data_2_o, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(bus.req_ready_o), 64'd1);

    // Directed corners
    run(1'b1, MULDIV_SIGN, MULDIV_SIGN, 64'd3, -64'sd5, 1'b1);
    run(1'b1, MULDIV_UNSIGN, MULDIV_UNSIGN, '1, '1, 1'b0);
    run(1'b0, MULDIV_SIGN, MULDIV_SIGN, -64'sd7, 64'd2, 1'b1);
    run(1'b0, MULDIV_UNSIGN, MULDIV_UNSIGN, 64'd7, 64'd2, 1'b0);
    run(1'b0, MULDIV_SIGN, MULDIV_SIGN, 64'd42, 64'd0, 1'b1);
    run(1'b0, MULDIV_SIGN, MULDIV_SIGN, 64'h8000_0000_0000_0000, '1, 1'b0);

    // Outputs hold the last result while idle
    repeat (3) @(negedge clk);
    chk("hold_data_1", bus.data_1_o, last_d1);
    chk("hold_data_2", bus.data_2_o, last_d2);

    // Flush mid-CALC: no strobe, data untouched, then a fresh op
    start(1'b1, MULDIV_UNSIGN, MULDIV_UNSIGN, 64'd5, 64'd9, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_ready", 64'(bus.req_ready_o), 64'd1);
    chk("flush_busy", 64'(bus.busy_o), 64'd0);
    chk("flush_data_1", bus.data_1_o, last_d1);
    run(1'b1, MULDIV_UNSIGN, MULDIV_UNSIGN, 64'd6, 64'd7, 1'b0);

    // Reset mid-CALC: outputs clear asynchronously, no strobe afterwards
    start(1'b0, MULDIV_SIGN, MULDIV_SIGN, 64'd1234, 64'd7, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.req_ready_o), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    chk("mid_rst_resp", 64'(bus.resp_valid_o), 64'd0);
    chk("mid_rst_data_1", bus.data_1_o, 64'd0);
    chk("mid_rst_data_2", bus.data_2_o, 64'd0);
    last_d1 = '0;
    last_d2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (80) @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready_o), 64'd1);

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          pick(), pick(), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d outstanding expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
